// File: rtl/pg_mmio_csr_bridge.sv
// AXI4 MMIO (single-beat) to CSR request/acknowledge bridge, one transaction in flight.
// Optional error logging (err_cnt_o/err_addr_o) is enabled by defining PG_MMIO_CSR_ERR_LOG_EN.
module pg_mmio_csr_bridge #(
  parameter int ADDR_W      = 18,
  parameter int DATA_W      = 64,
  parameter int ID_W        = 9,
  parameter int TIMEOUT_CYC = 256
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                awvalid_i,
  output logic                awready_o,
  input  logic [ID_W-1:0]     awid_i,
  input  logic [ADDR_W-1:0]   awaddr_i,
  input  logic [7:0]          awlen_i,
  input  logic [2:0]          awsize_i,
  input  logic                wvalid_i,
  output logic                wready_o,
  input  logic [DATA_W-1:0]   wdata_i,
  input  logic [DATA_W/8-1:0] wstrb_i,
  input  logic                wlast_i,
  output logic                bvalid_o,
  input  logic                bready_i,
  output logic [ID_W-1:0]     bid_o,
  output logic [1:0]          bresp_o,
  input  logic                arvalid_i,
  output logic                arready_o,
  input  logic [ID_W-1:0]     arid_i,
  input  logic [ADDR_W-1:0]   araddr_i,
  input  logic [7:0]          arlen_i,
  input  logic [2:0]          arsize_i,
  output logic                rvalid_o,
  input  logic                rready_i,
  output logic [ID_W-1:0]     rid_o,
  output logic [DATA_W-1:0]   rdata_o,
  output logic [1:0]          rresp_o,
  output logic                rlast_o,
  output logic                csr_wr_o,
  output logic                csr_rd_o,
  output logic [ADDR_W-1:0]   csr_addr_o,
  output logic [DATA_W-1:0]   csr_wdata_o,
  output logic [DATA_W/8-1:0] csr_wstrb_o,
  input  logic                csr_ack_i,
  input  logic [DATA_W-1:0]   csr_rdata_i
`ifdef PG_MMIO_CSR_ERR_LOG_EN
  ,
  output logic [15:0]         err_cnt_o,
  output logic [ADDR_W-1:0]   err_addr_o
`endif
);

  localparam int         STRB_W      = DATA_W / 8;
  localparam int         CNT_W       = $clog2(TIMEOUT_CYC);
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [2:0] {
    IDLE, WR_DATA, WR_REQ, RD_REQ, WR_RSP, RD_RSP, WR_DRAIN
  } state_e;

  state_e              state_q, state_d;
  logic [ID_W-1:0]     id_q, id_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [STRB_W-1:0]   wstrb_q, wstrb_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic [1:0]          resp_q, resp_d;
  logic [CNT_W-1:0]    tmo_q, tmo_d;
  logic                wr_pri_q, wr_pri_d;

  logic                grant_aw, grant_ar, tmo_hit;
  logic                err_evt;
  logic [ADDR_W-1:0]   err_evt_addr;

  // Round-robin only matters under contention; wr_pri_q names the favoured side.
  assign grant_aw = awvalid_i && (!arvalid_i || wr_pri_q);
  assign grant_ar = arvalid_i && !grant_aw;
  assign tmo_hit  = (tmo_q == CNT_W'(TIMEOUT_CYC - 1));

  always_comb begin
    // NOTE: every variable gets its hold value first so no path can infer a latch.
    state_d      = state_q;
    id_d         = id_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    wstrb_d      = wstrb_q;
    rdata_d      = rdata_q;
    resp_d       = resp_q;
    tmo_d        = tmo_q;
    wr_pri_d     = wr_pri_q;
    err_evt      = 1'b0;
    err_evt_addr = addr_q;

    unique case (state_q)
      IDLE: begin
        tmo_d = '0;
        if (grant_aw) begin
          id_d     = awid_i;
          addr_d   = awaddr_i;
          wr_pri_d = 1'b0;
          state_d  = (awlen_i == 8'd0) ? WR_DATA : WR_DRAIN;
        end else if (grant_ar) begin
          id_d     = arid_i;
          addr_d   = araddr_i;
          rdata_d  = '0;
          wr_pri_d = 1'b1;
          if (arlen_i == 8'd0) begin
            state_d = RD_REQ;
          end else begin
            resp_d       = RESP_SLVERR;
            err_evt      = 1'b1;
            err_evt_addr = araddr_i;
            state_d      = RD_RSP;
          end
        end
      end
      WR_DATA: begin
        if (wvalid_i) begin
          wdata_d = wdata_i;
          wstrb_d = wstrb_i;
          state_d = WR_REQ;
        end
      end
      WR_DRAIN: begin
        if (wvalid_i && wlast_i) begin
          resp_d  = RESP_SLVERR;
          err_evt = 1'b1;
          state_d = WR_RSP;
        end
      end
      WR_REQ, RD_REQ: begin
        // An ack landing on the timeout cycle still completes the access normally.
        if (csr_ack_i) begin
          resp_d = RESP_OKAY;
          if (state_q == RD_REQ) begin
            rdata_d = csr_rdata_i;
            state_d = RD_RSP;
          end else begin
            state_d = WR_RSP;
          end
        end else if (tmo_hit) begin
          resp_d  = RESP_SLVERR;
          rdata_d = '0;
          err_evt = 1'b1;
          state_d = (state_q == RD_REQ) ? RD_RSP : WR_RSP;
        end else begin
          tmo_d = tmo_q + CNT_W'(1);
        end
      end
      WR_RSP:  if (bready_i) state_d = IDLE;
      RD_RSP:  if (rready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      id_q     <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      wstrb_q  <= '0;
      rdata_q  <= '0;
      resp_q   <= RESP_OKAY;
      tmo_q    <= '0;
      wr_pri_q <= 1'b1;
    end else begin
      state_q  <= state_d;
      id_q     <= id_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      wstrb_q  <= wstrb_d;
      rdata_q  <= rdata_d;
      resp_q   <= resp_d;
      tmo_q    <= tmo_d;
      wr_pri_q <= wr_pri_d;
    end
  end

  assign awready_o   = (state_q == IDLE) && grant_aw;
  assign arready_o   = (state_q == IDLE) && grant_ar;
  assign wready_o    = (state_q == WR_DATA) || (state_q == WR_DRAIN);
  assign bvalid_o    = (state_q == WR_RSP);
  assign bid_o       = id_q;
  assign bresp_o     = resp_q;
  assign rvalid_o    = (state_q == RD_RSP);
  assign rid_o       = id_q;
  assign rdata_o     = rdata_q;
  assign rresp_o     = resp_q;
  assign rlast_o     = (state_q == RD_RSP);
  assign csr_wr_o    = (state_q == WR_REQ);
  assign csr_rd_o    = (state_q == RD_REQ);
  assign csr_addr_o  = addr_q;
  assign csr_wdata_o = wdata_q;
  assign csr_wstrb_o = wstrb_q;

`ifdef PG_MMIO_CSR_ERR_LOG_EN
  logic [15:0]       err_cnt_q;
  logic [ADDR_W-1:0] err_addr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt_q  <= '0;
      err_addr_q <= '0;
    end else if (err_evt) begin
      if (err_cnt_q != 16'hFFFF) err_cnt_q <= err_cnt_q + 16'd1;
      err_addr_q <= err_evt_addr;
    end
  end

  assign err_cnt_o  = err_cnt_q;
  assign err_addr_o = err_addr_q;
`else
  logic unused_err_log;
  assign unused_err_log = ^{err_evt, err_evt_addr};
`endif

  // Beat size is irrelevant: every access is a full DATA_W word.
  logic unused_size;
  assign unused_size = ^{awsize_i, arsize_i};

endmodule

// File: tb/tb_pg_mmio_csr_bridge.sv
// Self-checking bench for pg_mmio_csr_bridge: directed corner cases plus random single-channel
// traffic against a register-file model; optional checks when PG_MMIO_CSR_ERR_LOG_EN is defined.
module tb_pg_mmio_csr_bridge;

  localparam int ADDR_W = 18;
  localparam int DATA_W = 64;
  localparam int ID_W   = 9;
  localparam int STRB_W = DATA_W / 8;
  localparam int TMO    = 16;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              awvalid_i, awready_o;
  logic [ID_W-1:0]   awid_i;
  logic [ADDR_W-1:0] awaddr_i;
  logic [7:0]        awlen_i;
  logic [2:0]        awsize_i;
  logic              wvalid_i, wready_o;
  logic [DATA_W-1:0] wdata_i;
  logic [STRB_W-1:0] wstrb_i;
  logic              wlast_i;
  logic              bvalid_o, bready_i;
  logic [ID_W-1:0]   bid_o;
  logic [1:0]        bresp_o;
  logic              arvalid_i, arready_o;
  logic [ID_W-1:0]   arid_i;
  logic [ADDR_W-1:0] araddr_i;
  logic [7:0]        arlen_i;
  logic [2:0]        arsize_i;
  logic              rvalid_o, rready_i;
  logic [ID_W-1:0]   rid_o;
  logic [DATA_W-1:0] rdata_o;
  logic [1:0]        rresp_o;
  logic              rlast_o;
  logic              csr_wr_o, csr_rd_o;
  logic [ADDR_W-1:0] csr_addr_o;
  logic [DATA_W-1:0] csr_wdata_o;
  logic [STRB_W-1:0] csr_wstrb_o;
  logic              csr_ack_i;
  logic [DATA_W-1:0] csr_rdata_i;
`ifdef PG_MMIO_CSR_ERR_LOG_EN
  logic [15:0]       err_cnt_o;
  logic [ADDR_W-1:0] err_addr_o;
`endif

  always #5 clk = ~clk;

  pg_mmio_csr_bridge #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .ID_W(ID_W), .TIMEOUT_CYC(TMO)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .awvalid_i(awvalid_i), .awready_o(awready_o), .awid_i(awid_i), .awaddr_i(awaddr_i),
    .awlen_i(awlen_i), .awsize_i(awsize_i),
    .wvalid_i(wvalid_i), .wready_o(wready_o), .wdata_i(wdata_i), .wstrb_i(wstrb_i),
    .wlast_i(wlast_i),
    .bvalid_o(bvalid_o), .bready_i(bready_i), .bid_o(bid_o), .bresp_o(bresp_o),
    .arvalid_i(arvalid_i), .arready_o(arready_o), .arid_i(arid_i), .araddr_i(araddr_i),
    .arlen_i(arlen_i), .arsize_i(arsize_i),
    .rvalid_o(rvalid_o), .rready_i(rready_i), .rid_o(rid_o), .rdata_o(rdata_o),
    .rresp_o(rresp_o), .rlast_o(rlast_o),
    .csr_wr_o(csr_wr_o), .csr_rd_o(csr_rd_o), .csr_addr_o(csr_addr_o),
    .csr_wdata_o(csr_wdata_o), .csr_wstrb_o(csr_wstrb_o), .csr_ack_i(csr_ack_i),
    .csr_rdata_i(csr_rdata_i)
`ifdef PG_MMIO_CSR_ERR_LOG_EN
    , .err_cnt_o(err_cnt_o), .err_addr_o(err_addr_o)
`endif
  );

  int n_assert = 0;
  int n_fail   = 0;

  // Cumulative observation counters; the stimulus takes differences around each transaction.
  int wr_cyc = 0, rd_cyc = 0, rv_cyc = 0, both_rdy = 0, both_req = 0;
  always @(negedge clk) begin
    if (csr_wr_o) wr_cyc++;
    if (csr_rd_o) rd_cyc++;
    if (rvalid_o) rv_cyc++;
    if (awready_o && arready_o) both_rdy++;
    if (csr_wr_o && csr_rd_o) both_req++;
  end

  // Register-file model (expected) and the CSR device the bench emulates (driven by DUT outputs).
  logic [63:0] model_mem [int];
  logic [63:0] dev_mem   [int];
  logic [15:0]       exp_err_cnt  = '0;
  logic [ADDR_W-1:0] exp_err_addr = '0;

  function automatic logic [63:0] strb_mask(input logic [STRB_W-1:0] s);
    logic [63:0] m;
    for (int b = 0; b < STRB_W; b++) m[b*8 +: 8] = {8{s[b]}};
    return m;
  endfunction

  function automatic logic [63:0] model_read(input int a);
    return model_mem.exists(a) ? model_mem[a] : 64'd0;
  endfunction

  function automatic logic [63:0] dev_read(input int a);
    return dev_mem.exists(a) ? dev_mem[a] : 64'd0;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs();
    check("rst_awready", awready_o, 0);   check("rst_arready", arready_o, 0);
    check("rst_wready", wready_o, 0);     check("rst_bvalid", bvalid_o, 0);
    check("rst_bid", bid_o, 0);           check("rst_bresp", bresp_o, 0);
    check("rst_rvalid", rvalid_o, 0);     check("rst_rid", rid_o, 0);
    check("rst_rdata", rdata_o, 0);       check("rst_rresp", rresp_o, 0);
    check("rst_rlast", rlast_o, 0);       check("rst_csr_wr", csr_wr_o, 0);
    check("rst_csr_rd", csr_rd_o, 0);     check("rst_csr_addr", csr_addr_o, 0);
    check("rst_csr_wdata", csr_wdata_o, 0); check("rst_csr_wstrb", csr_wstrb_o, 0);
`ifdef PG_MMIO_CSR_ERR_LOG_EN
    check("rst_err_cnt", err_cnt_o, 0);   check("rst_err_addr", err_addr_o, 0);
`endif
  endtask

  task automatic note_err(input logic slverr, input logic [ADDR_W-1:0] addr);
    if (slverr) begin
      if (exp_err_cnt != 16'hFFFF) exp_err_cnt++;
      exp_err_addr = addr;
    end
`ifdef PG_MMIO_CSR_ERR_LOG_EN
    check("err_cnt", err_cnt_o, exp_err_cnt);
    check("err_addr", err_addr_o, exp_err_addr);
`endif
  endtask

  task automatic aw_phase(input logic [ID_W-1:0] id, input logic [ADDR_W-1:0] addr,
                          input logic [7:0] len);
    awvalid_i = 1'b1; awid_i = id; awaddr_i = addr; awlen_i = len; awsize_i = 3'($urandom);
    #1;
    check("aw_ready", awready_o, 1);
    check("aw_excl_arready", arready_o, 0);
    tick();
    awvalid_i = 1'b0;
  endtask

  task automatic ar_phase(input logic [ID_W-1:0] id, input logic [ADDR_W-1:0] addr,
                          input logic [7:0] len);
    arvalid_i = 1'b1; arid_i = id; araddr_i = addr; arlen_i = len; arsize_i = 3'($urandom);
    #1;
    check("ar_ready", arready_o, 1);
    check("ar_excl_awready", awready_o, 0);
    tick();
    arvalid_i = 1'b0;
  endtask

  task automatic w_phase(input logic [63:0] data, input logic [STRB_W-1:0] strb,
                         input int nbeats, input bit gaps);
    for (int i = 0; i < nbeats; i++) begin
      if (gaps && $urandom_range(0, 3) == 0) begin
        wvalid_i = 1'b0;
        tick();
      end
      wvalid_i = 1'b1;
      wdata_i  = (i == 0) ? data : {$urandom, $urandom};
      wstrb_i  = strb;
      wlast_i  = (i == nbeats - 1);
      #1;
      check("w_ready", wready_o, 1);
      tick();
    end
    wvalid_i = 1'b0;
    wlast_i  = 1'b0;
  endtask

  // Emulated CSR slave: acks after ack_dly request cycles, or never when ack_dly >= TMO.
  task automatic req_phase(input bit is_wr, input int ack_dly, input logic [ADDR_W-1:0] addr,
                           input logic [63:0] data, input logic [STRB_W-1:0] strb);
    for (int k = 0; k < TMO; k++) begin
      if (k == ack_dly) begin
        csr_ack_i = 1'b1;
        if (!is_wr) csr_rdata_i = dev_read(int'(csr_addr_o));
        #1;
        check(is_wr ? "csr_wr_at_ack" : "csr_rd_at_ack", is_wr ? csr_wr_o : csr_rd_o, 1);
        check("csr_addr", csr_addr_o, addr);
        if (is_wr) begin
          check("csr_wdata", csr_wdata_o, data);
          check("csr_wstrb", csr_wstrb_o, strb);
          dev_mem[int'(csr_addr_o)] = (dev_read(int'(csr_addr_o)) & ~strb_mask(csr_wstrb_o)) |
                                      (csr_wdata_o & strb_mask(csr_wstrb_o));
        end
        tick();
        csr_ack_i   = 1'b0;
        csr_rdata_i = {$urandom, $urandom};
        return;
      end
      csr_rdata_i = {$urandom, $urandom};
      tick();
    end
  endtask

  task automatic b_phase(input logic [ID_W-1:0] id, input logic [1:0] resp, input int rdly);
    bready_i = 1'b0;
    for (int i = 0; i < rdly; i++) begin
      #1;
      check("b_hold_valid", bvalid_o, 1);
      check("b_hold_resp", bresp_o, resp);
      tick();
    end
    bready_i = 1'b1;
    #1;
    check("bvalid", bvalid_o, 1);
    check("bid", bid_o, id);
    check("bresp", bresp_o, resp);
    tick();
    bready_i = 1'b0;
    #1;
    check("bvalid_clear", bvalid_o, 0);
  endtask

  task automatic r_phase(input logic [ID_W-1:0] id, input logic [1:0] resp,
                         input logic [63:0] data, input int rdly);
    rready_i = 1'b0;
    for (int i = 0; i < rdly; i++) begin
      #1;
      check("r_hold_valid", rvalid_o, 1);
      check("r_hold_resp", rresp_o, resp);
      check("r_hold_data", rdata_o, data);
      tick();
    end
    rready_i = 1'b1;
    #1;
    check("rvalid", rvalid_o, 1);
    check("rid", rid_o, id);
    check("rresp", rresp_o, resp);
    check("rdata", rdata_o, data);
    check("rlast", rlast_o, 1);
    tick();
    rready_i = 1'b0;
    #1;
    check("rvalid_clear", rvalid_o, 0);
  endtask

  task automatic wr_txn(input logic [ID_W-1:0] id, input logic [ADDR_W-1:0] addr,
                        input logic [7:0] len, input logic [63:0] data,
                        input logic [STRB_W-1:0] strb, input int ack_dly, input int rdly,
                        input bit gaps);
    int  wr0;
    bit  slverr;
    wr0    = wr_cyc;
    slverr = (len != 0) || (ack_dly >= TMO);
    aw_phase(id, addr, len);
    if (len != 0) begin
      w_phase(data, strb, int'(len) + 1, gaps);
    end else begin
      w_phase(data, strb, 1, gaps);
      req_phase(1'b1, ack_dly, addr, data, strb);
    end
    b_phase(id, slverr ? 2'b10 : 2'b00, rdly);
    check("wr_req_cycles", 64'(wr_cyc - wr0),
          64'((len != 0) ? 0 : ((ack_dly < TMO) ? ack_dly + 1 : TMO)));
    if (!slverr) model_mem[int'(addr)] = (model_read(int'(addr)) & ~strb_mask(strb)) |
                                         (data & strb_mask(strb));
    note_err(slverr, addr);
  endtask

  task automatic rd_txn(input logic [ID_W-1:0] id, input logic [ADDR_W-1:0] addr,
                        input logic [7:0] len, input int ack_dly, input int rdly);
    int  rd0;
    bit  slverr;
    rd0    = rd_cyc;
    slverr = (len != 0) || (ack_dly >= TMO);
    ar_phase(id, addr, len);
    if (len == 0) req_phase(1'b0, ack_dly, addr, '0, '0);
    r_phase(id, slverr ? 2'b10 : 2'b00, slverr ? 64'd0 : model_read(int'(addr)), rdly);
    check("rd_req_cycles", 64'(rd_cyc - rd0),
          64'((len != 0) ? 0 : ((ack_dly < TMO) ? ack_dly + 1 : TMO)));
    note_err(slverr, addr);
  endtask

  logic [ADDR_W-1:0] pool [4] = '{18'h00100, 18'h00208, 18'h003F8, 18'h3FFF8};

  initial begin
    logic [63:0] wd;
    int          dsel, ack_dly, rv0, rd0;
    logic [7:0]  len;

    rst_n = 1'b0;
    awvalid_i = 0; awid_i = 0; awaddr_i = 0; awlen_i = 0; awsize_i = 0;
    wvalid_i = 0; wdata_i = 0; wstrb_i = 0; wlast_i = 0; bready_i = 0;
    arvalid_i = 0; arid_i = 0; araddr_i = 0; arlen_i = 0; arsize_i = 0; rready_i = 0;
    csr_ack_i = 0; csr_rdata_i = 0;
    #1;
    check_reset_outputs();
    tick(); tick(); tick();
    #2 rst_n = 1'b1;
    tick();

    // Simultaneous AW/AR after reset: grants alternate starting with write.
    awvalid_i = 1'b1; awid_i = 9'h011; awaddr_i = 18'h003F8; awlen_i = 0;
    arvalid_i = 1'b1; arid_i = 9'h022; araddr_i = 18'h003F8; arlen_i = 0;
    for (int r = 0; r < 4; r++) begin
      #1;
      check("arb_aw_grant", awready_o, (r % 2 == 0));
      check("arb_ar_grant", arready_o, (r % 2 == 1));
      tick();
      if (r % 2 == 0) begin
        awvalid_i = 1'b0;
        wd = {$urandom, $urandom};
        w_phase(wd, 8'hFF, 1, 1'b0);
        req_phase(1'b1, 0, 18'h003F8, wd, 8'hFF);
        b_phase(awid_i, 2'b00, 0);
        model_mem[int'(18'h003F8)] = wd;
        awvalid_i = 1'b1; awid_i = awid_i + 9'd1;
      end else begin
        arvalid_i = 1'b0;
        req_phase(1'b0, 0, 18'h003F8, '0, '0);
        r_phase(arid_i, 2'b00, model_read(int'(18'h003F8)), 0);
        arvalid_i = 1'b1; arid_i = arid_i + 9'd1;
      end
    end
    awvalid_i = 1'b0;
    arvalid_i = 1'b0;

    // Minimum-latency write, then the directed read/timeout/burst corner cases.
    wr_txn(9'd5, 18'h00100, 8'd0, 64'hDEADBEEF_CAFEF00D, 8'hFF, 0, 0, 1'b0);
    dev_mem[int'(18'h00208)]   = 64'h1234;
    model_mem[int'(18'h00208)] = 64'h1234;
    rd_txn(9'd3, 18'h00208, 8'd0, 4, 1);
    rd_txn(9'h1A5, 18'h002A0, 8'd0, TMO + 5, 2);
    rd_txn(9'd7, 18'h00208, 8'd0, TMO - 1, 0);
    wr_txn(9'd6, 18'h00100, 8'd3, 64'h1111_2222_3333_4444, 8'hFF, 0, 1, 1'b0);
    rd_txn(9'd8, 18'h00100, 8'd2, 0, 1);
    wr_txn(9'd9, 18'h00208, 8'd0, 64'h5555_6666_7777_8888, 8'h0F, TMO + 2, 0, 1'b0);
    wr_txn(9'd10, 18'h00208, 8'd0, 64'hAAAA_BBBB_CCCC_DDDD, 8'hC3, 2, 0, 1'b1);
    rd_txn(9'd11, 18'h00208, 8'd0, 1, 0);

    // A stray ack in IDLE must not produce any response.
    csr_ack_i = 1'b1;
    tick();
    csr_ack_i = 1'b0;
    #1;
    check("stray_ack_bvalid", bvalid_o, 0);
    check("stray_ack_rvalid", rvalid_o, 0);

    for (int t = 0; t < 40; t++) begin
      dsel    = $urandom_range(0, 7);
      ack_dly = (dsel < 5) ? dsel : ((dsel == 5) ? TMO - 1 : TMO + 3);
      len     = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(1, 4)) : 8'd0;
      if ($urandom_range(0, 1) == 1)
        wr_txn(9'($urandom), pool[$urandom_range(0, 3)], len, {$urandom, $urandom},
               8'($urandom), ack_dly, $urandom_range(0, 2), 1'b1);
      else
        rd_txn(9'($urandom), pool[$urandom_range(0, 3)], len, ack_dly, $urandom_range(0, 2));
    end

    // Reset in the middle of a CSR read: everything clears and no response follows.
    ar_phase(9'h0AB, 18'h00100, 8'd0);
    tick(); tick();
    check("pre_reset_csr_rd", csr_rd_o, 1);
    #2 rst_n = 1'b0;
    #1;
    check_reset_outputs();
    exp_err_cnt  = '0;
    exp_err_addr = '0;
    tick(); tick();
    #2 rst_n = 1'b1;
    rv0 = rv_cyc;
    rd0 = rd_cyc;
    for (int i = 0; i < 20; i++) tick();
    check("post_reset_no_rvalid", 64'(rv_cyc - rv0), 0);
    check("post_reset_no_csr_rd", 64'(rd_cyc - rd0), 0);
    rd_txn(9'h0AC, 18'h00100, 8'd0, 2, 0);

    check("never_both_readies", 64'(both_rdy), 0);
    check("never_both_requests", 64'(both_req), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/pg_mmio_csr_bridge.md
Name: pg_mmio_csr_bridge

Overview:
- Terminates the AXI4 MMIO port produced by the port-gasket AXI-Lite-to-MMIO converter.
- Turns each single-beat AXI4 read or write into one request/acknowledge transaction on a simple CSR register-file interface.
- Returns B/R responses with the ID echoed back.
- Serialises traffic: one outstanding transaction total. Guards against CSR hangs with a timeout that returns SLVERR.

Parameters:
- ADDR_W, 18: AXI and CSR address width.
- DATA_W, 64: data width; wstrb width is DATA_W/8.
- ID_W, 9: AXI awid/arid/bid/rid width.
- TIMEOUT_CYC, 256: cycles to wait for csr_ack before the error response; must be >= 2.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous assert, active-low
- awvalid/awready  in/out  1  write address handshake
- awid  in  ID_W  write ID
- awaddr  in  ADDR_W  write address
- awlen  in  8  burst length
- awsize  in  3  beat size
- wvalid/wready  in/out  1  write data handshake
- wdata  in  DATA_W  write data
- wstrb  in  DATA_W/8  write byte strobes
- wlast  in  1  last write beat
- bvalid  out  1  write response valid
- bready  in  1  write response ready
- bid  out  ID_W  write response ID
- bresp  out  2  write response code
- arvalid/arready  in/out  1  read address handshake
- arid  in  ID_W  read ID
- araddr  in  ADDR_W  read address
- arlen  in  8  burst length
- arsize  in  3  beat size
- rvalid  out  1  read data valid
- rready  in  1  read data ready
- rid  out  ID_W  read ID
- rdata  out  DATA_W  read data
- rresp  out  2  read response code
- rlast  out  1  last read beat
- csr_wr  out  1  CSR write request
- csr_rd  out  1  CSR read request
- csr_addr  out  ADDR_W  CSR address
- csr_wdata  out  DATA_W  CSR write data
- csr_wstrb  out  DATA_W/8  CSR byte strobes
- csr_ack  in  1  CSR request completion
- csr_rdata  in  DATA_W  CSR read data, valid when csr_ack=1

Behaviour:
- Reset (asynchronous, rst_n=0):
  - all valid/ready/request outputs = 0; bresp/rresp = 0; bid/rid/rdata/csr_* buses = 0.
  - FSM returns to IDLE; arbiter pointer favours write; timeout counter = 0.
  - Reset mid-transaction drops the transaction silently; no response is issued.
- FSM states: IDLE, WR_DATA, WR_REQ, RD_REQ, WR_RSP, RD_RSP, WR_DRAIN.
- IDLE:
  - awready = arready = 1 only when the arbiter grants that channel; at most one of them is high in any cycle.
  - Arbiter: if only one of awvalid/arvalid is high, grant it. If both are high, round-robin: grant write first after reset, then alternate.
- AW handshake:
  - Latch awid, awaddr.
  - awlen==0 -> WR_DATA.
  - awlen!=0 (burst) -> WR_DRAIN, error path.
- WR_DATA: wready=1. On the W handshake, latch wdata/wstrb -> WR_REQ.
- WR_DRAIN:
  - wready=1; accept and discard beats until the beat with wlast=1.
  - Then WR_RSP with bresp=SLVERR (2'b10). No CSR access.
- WR_REQ / RD_REQ:
  - csr_wr (or csr_rd) held at 1 from state entry until the cycle csr_ack=1 is sampled; csr_addr/wdata/wstrb held stable throughout.
  - csr_ack=1: request drops the next cycle. Read: capture csr_rdata, resp=OKAY. Write: resp=OKAY. Go to RSP state.
  - The timeout counter increments each REQ cycle. Reaching TIMEOUT_CYC-1 with no ack: drop the request, set resp=SLVERR, rdata=0, go to RSP state.
  - csr_ack in the same cycle as the timeout wins: OKAY.
- AR handshake:
  - Latch arid, araddr -> RD_REQ.
  - arlen!=0: skip the CSR access and go straight to RD_RSP with rresp=SLVERR, rdata=0, single beat, rlast=1.
- WR_RSP: bvalid=1, bid=latched awid; hold until bready -> IDLE.
- RD_RSP: rvalid=1, rlast=1, rid=latched arid; hold until rready -> IDLE.
- Stray csr_ack outside the REQ states is ignored.
- Latency, ack=1 on the first REQ cycle, ready held high:
  - write: AW(c0), W(c1), REQ(c2), bvalid(c3).
  - read: AR(c0), REQ(c1), rvalid(c2).
- awsize/arsize are ignored; all accesses are treated as DATA_W wide.
- bresp/rresp/rdata are stable while valid=1 and ready=0.

Optional Feature:
- PG_MMIO_CSR_ERR_LOG_EN.
- Defined:
  - Adds output err_cnt[15:0]: increments on every SLVERR response (timeout or burst), saturates at 16'hFFFF.
  - Adds output err_addr[ADDR_W-1:0]: address of the most recent SLVERR transaction.
  - Both reset to 0.
- Undefined: these ports and registers are absent; behaviour is otherwise identical.

Test Plan:
- Write awid=5, awaddr=0x100, wdata=0xDEADBEEF_CAFEF00D, wstrb=0xFF; ack on first REQ cycle -> csr_wr held one cycle with those values; bvalid at c3, bid=5, bresp=0.
- Read arid=3, araddr=0x208; csr_rdata=0x1234 with ack after 4 cycles -> csr_rd high 5 cycles; rdata=0x1234, rid=3, rresp=0, rlast=1.
- Read with csr_ack never asserted, TIMEOUT_CYC=16 -> csr_rd drops after 16 cycles; rresp=2, rdata=0; if ERR_LOG enabled, err_cnt=1 and err_addr=araddr.
- awvalid and arvalid high together, repeated 4 times after reset -> grant order W,R,W,R; never both readies high.
- awlen=3 write with 4 W beats, wlast on the 4th -> no csr_wr; single bresp=2 after the 4th beat.
- rst_n pulsed low during RD_REQ with rready=0 -> all outputs 0 immediately; no rvalid afterwards; next read completes OKAY.
